// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flags register.
// Sequencing is owned by the control unit; this block only reacts to its strobes.

package data_path_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BOV,
        I_BNZERO,
        I_BNNEG,
        I_BNOV,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;
endpackage

module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    localparam int MSB = DATA_W - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] regFile_q [4];
    logic [DATA_W-1:0] regFile_d [4];
    logic              zeroFlag_q, zeroFlag_d;
    logic              negFlag_q, negFlag_d;
    logic              carryFlag_q, carryFlag_d;
    logic              ovfFlag_q, ovfFlag_d;

    logic [1:0]        srcASel;
    logic [1:0]        srcBSel;
    logic [1:0]        destSel;
    logic              regWriteAllowed;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W:0]   sumWide;
    logic [DATA_W:0]   diffWide;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;
    logic              aluOverflow;
    logic [DATA_W-1:0] writeData;
    logic              unusedBits;

    // Bit 7 of the instruction word carries no field in any format.
    assign unusedBits = ir_q[7];

    always_comb begin
        decoded_instruction = I_NOP;
        case (ir_q[15:8])
            8'h00:   decoded_instruction = I_NOP;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h04:   decoded_instruction = I_BOV;
            8'h05:   decoded_instruction = I_BNZERO;
            8'h06:   decoded_instruction = I_BNNEG;
            8'h07:   decoded_instruction = I_BNOV;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE routes its source to both ALU ports so that OR passes it through unchanged.
    always_comb begin
        srcASel         = ir_q[3:2];
        srcBSel         = ir_q[1:0];
        destSel         = ir_q[5:4];
        regWriteAllowed = 1'b0;
        case (decoded_instruction)
            I_LOAD: begin
                destSel         = ir_q[6:5];
                regWriteAllowed = 1'b1;
            end
            I_MOVE: begin
                destSel         = ir_q[3:2];
                srcASel         = ir_q[1:0];
                regWriteAllowed = 1'b1;
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
                regWriteAllowed = 1'b1;
            end
            default: begin
                regWriteAllowed = 1'b0;
            end
        endcase
    end

    always_comb begin
        opA         = regFile_q[srcASel];
        opB         = regFile_q[srcBSel];
        sumWide     = {1'b0, opA} + {1'b0, opB};
        diffWide    = {1'b0, opA} - {1'b0, opB};
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (operation)
            2'b00: begin
                aluResult = opA | opB;
            end
            2'b01: begin
                aluResult   = sumWide[MSB:0];
                aluCarry    = sumWide[DATA_W];
                aluOverflow = (opA[MSB] == opB[MSB]) && (aluResult[MSB] != opA[MSB]);
            end
            2'b10: begin
                aluResult   = diffWide[MSB:0];
                aluCarry    = diffWide[DATA_W];
                aluOverflow = (opA[MSB] != opB[MSB]) && (aluResult[MSB] != opA[MSB]);
            end
            default: begin
                aluResult = opA & opB;
            end
        endcase
    end

    assign writeData = c_sel ? aluResult : data_in;

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        regFile_d   = regFile_q;
        zeroFlag_d  = zeroFlag_q;
        negFlag_d   = negFlag_q;
        carryFlag_d = carryFlag_q;
        ovfFlag_d   = ovfFlag_q;

        if (pc_enable) begin
            pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
        if (ir_enable) begin
            ir_d = data_in;
        end
        // Stores and branches also see write_reg_enable; only real producers may write.
        if (write_reg_enable && regWriteAllowed) begin
            regFile_d[destSel] = writeData;
        end
        if (flags_reg_enable) begin
            zeroFlag_d  = (aluResult == '0);
            negFlag_d   = aluResult[MSB];
            carryFlag_d = aluCarry;
            ovfFlag_d   = aluOverflow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            zeroFlag_q  <= 1'b0;
            negFlag_q   <= 1'b0;
            carryFlag_q <= 1'b0;
            ovfFlag_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            zeroFlag_q  <= zeroFlag_d;
            negFlag_q   <= negFlag_d;
            carryFlag_q <= carryFlag_d;
            ovfFlag_q   <= ovfFlag_d;
            for (int i = 0; i < 4; i++) begin
                regFile_q[i] <= regFile_d[i];
            end
        end
    end

    assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign data_out          = regFile_q[ir_q[6:5]];
    assign zero_op           = zeroFlag_q;
    assign neg_op            = negFlag_q;
    assign unsigned_overflow = carryFlag_q;
    assign signed_overflow   = ovfFlag_q;

endmodule
